// File: rtl/instruction_fetch.sv
// Instruction fetch: steers the program counter, reads program ROM and hands {opcode, operand} words to the ICU.
// Optional address range checking with a sticky addr_fault output is enabled by defining IFETCH_ADDR_CHECK_EN.
module instruction_fetch #(
  parameter int                   ADDR_SIZE    = 8,
  parameter int                   OPERAND_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0
`ifdef IFETCH_ADDR_CHECK_EN
  , parameter int                 PROG_DEPTH   = 2**ADDR_SIZE
`endif
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [ADDR_SIZE-1:0]      pc_address_i,
  output logic                      pc_write_o,
  output logic [ADDR_SIZE-1:0]      pc_address_in_o,
  output logic                      rom_en_o,
  input  logic [OPERAND_SIZE+3:0]   rom_data_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [3:0]                instr_opcode_o,
  output logic [OPERAND_SIZE-1:0]   instr_operand_o,
  output logic [ADDR_SIZE-1:0]      instr_addr_o,
  input  logic                      jump_req_i,
  input  logic [ADDR_SIZE-1:0]      jump_target_i,
  input  logic                      skip_req_i
`ifdef IFETCH_ADDR_CHECK_EN
  , output logic                    addr_fault_o
`endif
);

  typedef enum logic [1:0] {SYNC, FETCH, PRESENT} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_SIZE-1:0]    fetch_addr_q;
  logic [OPERAND_SIZE+3:0] hold_q;
  logic                    entry_q;
  logic                    accept;
  logic                    fetch_ok;
  logic                    jump_ok;
  logic [OPERAND_SIZE+3:0] word;

`ifdef IFETCH_ADDR_CHECK_EN
  localparam logic [31:0] DEPTH_U = 32'(PROG_DEPTH);
  logic fault_q, fault_set;

  assign fetch_ok     = 32'(pc_address_i)  < DEPTH_U;
  assign jump_ok      = 32'(jump_target_i) < DEPTH_U;
  assign addr_fault_o = fault_q;
`else
  assign fetch_ok = 1'b1;
  assign jump_ok  = 1'b1;
`endif

  assign accept = (state_q == PRESENT) && instr_ready_i;

  always_comb begin
    state_d         = state_q;
    pc_write_o      = 1'b1;
    pc_address_in_o = pc_address_i;
    rom_en_o        = 1'b0;
`ifdef IFETCH_ADDR_CHECK_EN
    fault_set       = 1'b0;
`endif
    unique case (state_q)
      SYNC: begin
        // PC powers up at all ones; force it onto the reset vector.
        pc_address_in_o = RESET_VECTOR;
        state_d         = FETCH;
      end
      FETCH: begin
        pc_write_o = 1'b0;
        if (fetch_ok) begin
          rom_en_o = 1'b1;
          state_d  = PRESENT;
        end else begin
`ifdef IFETCH_ADDR_CHECK_EN
          fault_set = 1'b1;
`endif
          state_d = SYNC;
        end
      end
      PRESENT: begin
        // PC already points at fetch_addr+1; rewriting it holds it there.
        if (accept) begin
          state_d = FETCH;
          if (jump_req_i) begin
            if (jump_ok) begin
              pc_address_in_o = jump_target_i;
            end else begin
              pc_address_in_o = RESET_VECTOR;
`ifdef IFETCH_ADDR_CHECK_EN
              fault_set = 1'b1;
`endif
            end
          end else if (skip_req_i) begin
            pc_address_in_o = pc_address_i + 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= SYNC;
      fetch_addr_q <= '0;
      hold_q       <= '0;
      entry_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_q == FETCH) && (state_d == PRESENT);
      if (state_q == FETCH) fetch_addr_q <= pc_address_i;
      if (entry_q)          hold_q       <= rom_data_i;
    end
  end

`ifdef IFETCH_ADDR_CHECK_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) fault_q <= 1'b0;
    else            fault_q <= fault_q | fault_set;
  end
`endif

  // ROM data is live only in the entry cycle; afterwards the captured copy keeps the word stable.
  assign word            = entry_q ? rom_data_i : hold_q;
  assign instr_valid_o   = (state_q == PRESENT);
  assign instr_opcode_o  = word[OPERAND_SIZE+3 -: 4];
  assign instr_operand_o = word[OPERAND_SIZE-1:0];
  assign instr_addr_o    = fetch_addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC and ROM models around the DUT, with an address-sequence reference model.
module tb_instruction_fetch;
  localparam int         AW = 8;
  localparam int         OW = 8;
  localparam logic [7:0] RV = 8'h10;
`ifdef IFETCH_ADDR_CHECK_EN
  localparam int DEPTH = 64;
`else
  localparam int DEPTH = 256;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] pc;
  logic          pc_write;
  logic [AW-1:0] pc_in;
  logic          rom_en;
  logic [OW+3:0] rom_data;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [3:0]    instr_opcode;
  logic [OW-1:0] instr_operand;
  logic [AW-1:0] instr_addr;
  logic          jump_req = 1'b0;
  logic [AW-1:0] jump_target = '0;
  logic          skip_req = 1'b0;
  logic          addr_fault;

  logic [OW+3:0] mem [256];
  int            checks = 0;
  int            errors = 0;
  logic [7:0]    m_addr;
  int            m_gap;
  logic          m_fault;
  logic          m_pend;

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_SIZE(AW), .OPERAND_SIZE(OW), .RESET_VECTOR(RV)
`ifdef IFETCH_ADDR_CHECK_EN
    , .PROG_DEPTH(DEPTH)
`endif
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .pc_address_i(pc), .pc_write_o(pc_write), .pc_address_in_o(pc_in),
    .rom_en_o(rom_en), .rom_data_i(rom_data),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_opcode_o(instr_opcode), .instr_operand_o(instr_operand), .instr_addr_o(instr_addr),
    .jump_req_i(jump_req), .jump_target_i(jump_target), .skip_req_i(skip_req)
`ifdef IFETCH_ADDR_CHECK_EN
    , .addr_fault_o(addr_fault)
`endif
  );

`ifndef IFETCH_ADDR_CHECK_EN
  assign addr_fault = 1'b0;
`endif

  // Program counter: loads on write, otherwise counts up; powers up at all ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pc <= '1;
    else if (pc_write) pc <= pc_in;
    else               pc <= pc + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= mem[pc];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model tracks which word should be on the bus and how many idle cycles precede it.
  task automatic step(input logic rdy, input logic jmp, input logic skp, input logic [7:0] tgt);
    logic [7:0] nxt;
    @(negedge clk);
    instr_ready = rdy; jump_req = jmp; skip_req = skp; jump_target = tgt;
    #1;
`ifdef IFETCH_ADDR_CHECK_EN
    chk("addr_fault", 32'(addr_fault), 32'(m_fault));
`endif
    if (m_gap > 0) begin
      chk("valid_idle", 32'(instr_valid), 32'd0);
      if (m_gap == 1) begin
        chk("rom_en_fetch", 32'(rom_en), 32'd1);
        chk("pc_write_fetch", 32'(pc_write), 32'd0);
      end
      if (m_pend) begin m_fault = 1'b1; m_pend = 1'b0; end
      m_gap--;
    end else begin
      chk("valid", 32'(instr_valid), 32'd1);
      chk("instr_addr", 32'(instr_addr), 32'(m_addr));
      chk("opcode", 32'(instr_opcode), 32'(mem[m_addr][OW+3 -: 4]));
      chk("operand", 32'(instr_operand), 32'(mem[m_addr][OW-1:0]));
      chk("pc_write_present", 32'(pc_write), 32'd1);
      if (!rdy) begin
        nxt = m_addr + 8'd1;
        chk("pc_hold", 32'(pc_in), 32'(nxt));
      end else begin
        nxt = jmp ? tgt : (skp ? m_addr + 8'd2 : m_addr + 8'd1);
        if (jmp && int'(tgt) >= DEPTH) begin
          chk("pc_in_badjump", 32'(pc_in), 32'(RV));
          m_fault = 1'b1; m_addr = RV; m_gap = 1;
        end else begin
          chk("pc_in_accept", 32'(pc_in), 32'(nxt));
          if (int'(nxt) >= DEPTH) begin
            m_pend = 1'b1; m_addr = RV; m_gap = 3;
          end else begin
            m_addr = nxt; m_gap = 1;
          end
        end
      end
    end
  endtask

  // Runs out any idle cycles with random (ignored) handshake inputs, then presents one step on a valid word.
  task automatic present(input logic rdy, input logic jmp, input logic skp, input logic [7:0] tgt);
    for (int i = 0; i < 4 && m_gap > 0; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    step(rdy, jmp, skp, tgt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_pc_in", 32'(pc_in), 32'(RV));
    chk("rst_addr", 32'(instr_addr), 32'd0);
    chk("rst_opcode", 32'(instr_opcode), 32'd0);
    chk("rst_operand", 32'(instr_operand), 32'd0);
    chk("rst_fault", 32'(addr_fault), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("sync_pc_write", 32'(pc_write), 32'd1);
    chk("sync_pc_in", 32'(pc_in), 32'(RV));
    chk("sync_rom_en", 32'(rom_en), 32'd0);
    m_addr = RV; m_gap = 1; m_fault = 1'b0; m_pend = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    do_reset();
    // Ready held high: 10, 11, 12 presented on alternate cycles.
    repeat (6) step(1'b1, 1'b0, 1'b0, 8'h00);
    present(1'b1, 1'b1, 1'b0, 8'h20);
    // Stall on @20: word stable, PC held at 21.
    repeat (5) present(1'b0, 1'b0, 1'b0, 8'h00);
    present(1'b1, 1'b1, 1'b0, 8'h30);
    // Jump wins over skip.
    present(1'b1, 1'b1, 1'b1, 8'h05);
    present(1'b1, 1'b1, 1'b0, 8'hFE);
    // Skip from FE wraps past FF to 00.
    present(1'b1, 1'b0, 1'b1, 8'h00);
    present(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef IFETCH_ADDR_CHECK_EN
    present(1'b1, 1'b1, 1'b0, 8'h40);
    present(1'b1, 1'b0, 1'b0, 8'h00);
    present(1'b1, 1'b0, 1'b0, 8'h00);
`endif
    repeat (300)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
    // Reset asserted while a word is presented.
    present(1'b0, 1'b0, 1'b0, 8'h00);
    do_reset();
    repeat (8) step(1'b1, 1'b0, 1'b0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
